// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_pkg
// Purpose  : Shared types and helpers for the sequential neuron layer.
// Revision : 1.0 - initial release
// ============================================================================
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Clamp a signed value into the unsigned range [0, 2^width-1].
    function automatic logic [63:0] sat_unsigned(input logic signed [63:0] value,
                                                 input int width);
        logic [63:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        if (value < 0)
            return 64'd0;
        else if ($unsigned(value) > max_v)
            return max_v;
        return $unsigned(value);
    endfunction

    function automatic int acc_w_req(input int data_w, input int in_w);
        return 2 * data_w + 1 + $clog2(in_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_mac_lane.sv
`default_nettype none
// ============================================================================
// Module   : nn_mac_lane
// Purpose  : One neuron lane: bias load, signed x unsigned MAC, shift+activate.
// Revision : 1.0 - initial release
// ============================================================================
module nn_mac_lane
    import nn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 7,
    parameter int RELU   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bias_load,
    input  logic                     mac_en,
    input  logic signed [DATA_W-1:0] w,
    input  logic        [DATA_W-1:0] x,
    output logic        [DATA_W-1:0] act
);

    logic signed [ACC_W-1:0]    r_acc;
    logic signed [2*DATA_W:0]   w_prod;
    logic signed [ACC_W-1:0]    w_bias_ext;
    logic signed [ACC_W-1:0]    w_shifted;
    logic signed [63:0]         w_v;

    // Activation is zero-extended so the product keeps its true sign.
    assign w_prod     = w * $signed({1'b0, x});
    assign w_bias_ext = ACC_W'(w) <<< SHIFT;

    always_ff @(posedge clk) begin
        if (rst)
            r_acc <= '0;
        else if (bias_load)
            r_acc <= w_bias_ext;
        else if (mac_en)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

    assign w_shifted = r_acc >>> SHIFT;
    assign w_v       = 64'(w_shifted);

    generate
        if (RELU != 0) begin : g_relu
            assign act = DATA_W'(sat_unsigned(w_v, DATA_W));
        end else begin : g_offset
            assign act = DATA_W'(sat_unsigned(w_v + (64'sd1 <<< (DATA_W - 1)), DATA_W));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/nn_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : nn_layer_seq
// Purpose  : Time-multiplexed fully connected layer, LANES neurons per pass.
// Revision : 1.0 - initial release
// ============================================================================
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int IN_W   = 784,
    parameter int OUT_W  = 16,
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 7,
    parameter int RELU   = 1,
    parameter int AW     = $clog2(((OUT_W + LANES - 1) / LANES) * (IN_W + 1))
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_W*DATA_W-1:0]    in_data,
    output logic                      w_en,
    output logic [AW-1:0]             w_addr,
    input  logic [LANES*DATA_W-1:0]   w_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W*DATA_W-1:0]   out_data,
    output logic                      busy
);

    localparam int c_groups = (OUT_W + LANES - 1) / LANES;
    localparam int c_kw     = $clog2(IN_W + 1);
    localparam int c_gw     = $clog2(c_groups + 1);

    generate
        if (ACC_W < acc_w_req(DATA_W, IN_W)) begin : g_acc_chk
            $error("nn_layer_seq: ACC_W too small for DATA_W/IN_W");
        end
    endgenerate

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IN_W*DATA_W-1:0]     r_x;
    logic [IN_W*DATA_W-1:0]     w_x_rot;
    logic [c_kw-1:0]            r_k;
    logic [c_gw-1:0]            r_g;
    logic [AW-1:0]              r_addr;
    logic                       r_ret_valid;
    logic                       r_ret_bias;
    logic                       w_k_last;
    logic                       w_g_last;
    logic [LANES*DATA_W-1:0]    w_act;
    logic [OUT_W*DATA_W-1:0]    w_out;

    assign w_k_last = (r_k == c_kw'(IN_W));
    assign w_g_last = (r_g == c_gw'(c_groups - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = ISSUE;
            ISSUE:   if (w_k_last) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = WRITE;
            WRITE:   w_state_nxt = w_g_last ? DONE : ISSUE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Input register rotates one element per weight return, so the current
    // activation is always in the low slot and the vector is restored after
    // every group.
    generate
        if (IN_W > 1) begin : g_rot
            assign w_x_rot = {r_x[DATA_W-1:0], r_x[IN_W*DATA_W-1:DATA_W]};
        end else begin : g_rot_one
            assign w_x_rot = r_x;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_k         <= '0;
            r_g         <= '0;
            r_addr      <= '0;
            r_ret_valid <= 1'b0;
            r_ret_bias  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_valid <= (r_state == ISSUE);
            r_ret_bias  <= (r_state == ISSUE) && (r_k == '0);
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x    <= in_data;
                        r_k    <= '0;
                        r_g    <= '0;
                        r_addr <= '0;
                    end
                end
                // Addresses are contiguous across groups, so a free-running
                // counter during ISSUE lands on the next group's base.
                ISSUE: begin
                    r_addr <= r_addr + 1'b1;
                    if (!w_k_last)
                        r_k <= r_k + 1'b1;
                end
                WRITE: begin
                    r_k <= '0;
                    r_g <= r_g + 1'b1;
                end
                default: ;
            endcase
            if (r_ret_valid && !r_ret_bias)
                r_x <= w_x_rot;
        end
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            nn_mac_lane #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SHIFT  (SHIFT),
                .RELU   (RELU)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .bias_load (r_ret_valid && r_ret_bias),
                .mac_en    (r_ret_valid && !r_ret_bias),
                .w         (w_data[l*DATA_W +: DATA_W]),
                .x         (r_x[DATA_W-1:0]),
                .act       (w_act[l*DATA_W +: DATA_W])
            );
        end

        for (genvar n = 0; n < OUT_W; n++) begin : g_out
            localparam int c_grp  = n / LANES;
            localparam int c_lane = n % LANES;
            logic [DATA_W-1:0] r_val;

            always_ff @(posedge clk) begin
                if (rst)
                    r_val <= '0;
                else if (r_state == WRITE && r_g == c_gw'(c_grp))
                    r_val <= w_act[c_lane*DATA_W +: DATA_W];
            end

            assign w_out[n*DATA_W +: DATA_W] = r_val;
        end
    endgenerate

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign w_en      = (r_state == ISSUE);
    assign w_addr    = r_addr;
    assign out_data  = w_out;

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_layer_seq
// Purpose  : Directed bench; four configurations (SHIFT 0/2 x RELU 1/0) in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_layer_seq;

    localparam int IN_W   = 2;
    localparam int OUT_W  = 3;
    localparam int LANES  = 2;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int AW     = 3;
    localparam int NDUT   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [IN_W*DATA_W-1:0] in_data = '0;

    logic                      in_ready_v  [NDUT];
    logic                      out_valid_v [NDUT];
    logic                      w_en_v      [NDUT];
    logic                      busy_v      [NDUT];
    logic [AW-1:0]             w_addr_v    [NDUT];
    logic [LANES*DATA_W-1:0]   w_data_v    [NDUT];
    logic [OUT_W*DATA_W-1:0]   out_data_v  [NDUT];

    logic [15:0] mem_s0 [0:7];
    logic [15:0] mem_s2 [0:7];

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [AW-1:0] addr_q [$];

    // Expected {n2,n1,n0} per DUT: 0=S0/ReLU, 1=S0/offset, 2=S2/ReLU, 3=S2/offset
    logic [23:0] exp_v1 [NDUT] = '{24'hFF0010, 24'hFF7990, 24'hFF0010, 24'hFF7990};
    logic [23:0] exp_v2 [NDUT] = '{24'hFF000C, 24'hFF7A8C, 24'hFA000C, 24'hFF7A8C};

    always #5 clk = ~clk;

    generate
        for (genvar i = 0; i < NDUT; i++) begin : g_dut
            localparam int c_shift = (i >= 2) ? 2 : 0;
            localparam int c_relu  = (i % 2 == 0) ? 1 : 0;
            logic [15:0] r_wd;

            always_ff @(posedge clk)
                if (w_en_v[i])
                    r_wd <= (c_shift == 2) ? mem_s2[w_addr_v[i]] : mem_s0[w_addr_v[i]];
            assign w_data_v[i] = r_wd;

            nn_layer_seq #(
                .IN_W (IN_W), .OUT_W (OUT_W), .LANES (LANES), .DATA_W (DATA_W),
                .ACC_W (ACC_W), .SHIFT (c_shift), .RELU (c_relu), .AW (AW)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready_v[i]),
                .in_data   (in_data),
                .w_en      (w_en_v[i]),
                .w_addr    (w_addr_v[i]),
                .w_data    (w_data_v[i]),
                .out_valid (out_valid_v[i]),
                .out_ready (out_ready),
                .out_data  (out_data_v[i]),
                .busy      (busy_v[i])
            );
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts cycles from the accepting edge until out_valid, logging issued addresses.
    task automatic wait_out(output int n);
        n = 0;
        addr_q.delete();
        while (!out_valid_v[0] && n < 50) begin
            if (w_en_v[0])
                addr_q.push_back(w_addr_v[0]);
            tick();
            n++;
        end
    endtask

    task automatic check_all(input string tag, input logic [23:0] exp [NDUT]);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("%s_dut%0d", tag, i), 64'(out_data_v[i]), 64'(exp[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // SHIFT=0 table: n0 w=[1,2] b=5; n1 w=[-1,-1] b=0; n2 w=[100,100] b=100
        mem_s0[0] = 16'h0005; mem_s0[1] = 16'hFF01; mem_s0[2] = 16'hFF02;
        mem_s0[3] = 16'h7F64; mem_s0[4] = 16'h7F64; mem_s0[5] = 16'h7F64;
        mem_s0[6] = 16'h0000; mem_s0[7] = 16'h0000;
        // SHIFT=2 table: n0 w=[4,8] b=5; n1 w=[-4,-4] b=0; n2 as above
        mem_s2[0] = 16'h0005; mem_s2[1] = 16'hFC04; mem_s2[2] = 16'hFC08;
        mem_s2[3] = 16'h7F64; mem_s2[4] = 16'h7F64; mem_s2[5] = 16'h7F64;
        mem_s2[6] = 16'h0000; mem_s2[7] = 16'h0000;

        // Reset state
        tick(); tick();
        check("rst_in_ready",  64'(in_ready_v[0]),  64'd1);
        check("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("rst_out_data",  64'(out_data_v[0]),  64'd0);
        check("rst_w_en",      64'(w_en_v[0]),      64'd0);
        check("rst_w_addr",    64'(w_addr_v[0]),    64'd0);
        check("rst_busy",      64'(busy_v[0]),      64'd0);
        rst = 1'b0;

        // Basic inference x=[3,4]
        in_valid = 1'b1; in_data = 16'h0403;
        tick();
        in_valid = 1'b0;
        check("accept_busy", 64'(busy_v[0]), 64'd1);
        wait_out(cyc);
        check("latency1", 64'(cyc), 64'd10);
        check("addr_count", 64'(addr_q.size()), 64'd6);
        for (int i = 0; i < addr_q.size() && i < 6; i++)
            check($sformatf("addr%0d", i), 64'(addr_q[i]), 64'(i));
        check_all("basic", exp_v1);

        // Backpressure for 20 cycles
        for (int c = 0; c < 20; c++) begin
            check("bp_out_valid", 64'(out_valid_v[0]), 64'd1);
            check("bp_out_data",  64'(out_data_v[0]),  64'(exp_v1[0]));
            check("bp_in_ready",  64'(in_ready_v[0]),  64'd0);
            check("bp_w_en",      64'(w_en_v[0]),      64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("hs_in_ready",  64'(in_ready_v[0]),  64'd1);
        check("hs_data_held", 64'(out_data_v[0]),  64'(exp_v1[0]));

        // Reset four cycles after accept
        in_valid = 1'b1; in_data = 16'h0403;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("mrst_in_ready",  64'(in_ready_v[0]),  64'd1);
        check("mrst_busy",      64'(busy_v[0]),      64'd0);
        check("mrst_w_en",      64'(w_en_v[0]),      64'd0);
        check("mrst_out_data",  64'(out_data_v[0]),  64'd0);
        in_valid = 1'b1; in_data = 16'h0403;
        tick();
        in_valid = 1'b0;
        wait_out(cyc);
        check("latency_after_rst", 64'(cyc), 64'd10);
        check_all("after_rst", exp_v1);
        out_ready = 1'b1;
        tick();
        check("hs2_out_valid", 64'(out_valid_v[0]), 64'd0);

        // Back-to-back: x=[3,4] then x=[5,1] with in_valid held
        in_valid = 1'b1; in_data = 16'h0403;
        tick();
        in_data = 16'h0105;
        wait_out(cyc);
        check("b2b_latency1", 64'(cyc), 64'd10);
        check_all("b2b_v1", exp_v1);
        tick();
        check("b2b_hs_in_ready",  64'(in_ready_v[0]),  64'd1);
        check("b2b_hs_out_valid", 64'(out_valid_v[0]), 64'd0);
        tick();
        in_valid = 1'b0;
        check("b2b_accept_in_ready", 64'(in_ready_v[0]), 64'd0);
        check("b2b_accept_w_en",     64'(w_en_v[0]),     64'd1);
        check("b2b_accept_w_addr",   64'(w_addr_v[0]),   64'd0);
        wait_out(cyc);
        check("b2b_latency2", 64'(cyc), 64'd10);
        check_all("b2b_v2", exp_v2);
        tick();
        check("b2b_final_out_valid", 64'(out_valid_v[0]), 64'd0);
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
